// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : mem_copy_engine
//  Purpose  : Byte-serial memory copy initiator (READ/WRITE per byte).
//             Define MEM_COPY_CHECKSUM_EN to add a running byte checksum output.
//  Revision : 1.0  initial release
// ============================================================================
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            count_d = len;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        buf_d   = mem_rdata;
        src_d   = src_q + 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dst_d   = dst_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = (count_q == {{(ADDR_W-1){1'b0}}, 1'b1}) ? S_DONE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs decode registered state only; no input-to-output paths.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      S_READ:  mem_addr = src_q;
      S_WRITE: mem_addr = dst_q;
      default: mem_addr = '0;
    endcase
  end

  assign mem_write = (state_q == S_WRITE);
  assign mem_wdata = buf_q;
  assign busy      = (state_q == S_READ) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      checksum_q <= '0;
    end else if (state_q == S_READ) begin
      checksum_q <= checksum_q + mem_rdata;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_copy_engine
//  Purpose  : Directed self-checking bench for mem_copy_engine with a
//             behavioural 256-byte memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] src_addr, dst_addr, len;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic       busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;
  int busy_cnt, wr_cnt, done_cnt;
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // Activity monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (busy)      busy_cnt++;
    if (done)      done_cnt++;
    if (mem_write) begin
      wr_cnt++;
      wr_q.push_back(mem_addr);
    end else if (busy) begin
      rd_q.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
    rd_q.delete(); wr_q.delete();
  endtask

  // Issues one start and returns with the DUT in its first post-accept cycle.
  task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    clear_mon();
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 100) begin
      step();
      k++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int k;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    step(); step();
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_write", {31'd0, mem_write}, 32'd0);
    chk("rst_addr",  {24'd0, mem_addr},  32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("rst_csum",  {24'd0, checksum},  32'd0);
`endif
    rst = 1'b0;
    step();

    // Reset during the second WRITE of a 4-byte copy.
    mem[8'h60] = 8'hB0; mem[8'h61] = 8'hB1; mem[8'h62] = 8'hB2; mem[8'h63] = 8'hB3;
    kick(8'h60, 8'h70, 8'd4);
    step(); step(); step();
    chk("midrst_in_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_busy",  {31'd0, busy},      32'd0);
    chk("midrst_write", {31'd0, mem_write}, 32'd0);
    chk("midrst_done",  {31'd0, done},      32'd0);
    rst = 1'b0;
    step(); step();
    chk("midrst_m70", {24'd0, mem[8'h70]}, 32'h0B0);
    chk("midrst_m71", {24'd0, mem[8'h71]}, 32'h0B1);
    chk("midrst_m72", {24'd0, mem[8'h72]}, 32'h000);
    chk("midrst_m73", {24'd0, mem[8'h73]}, 32'h000);

    // Basic 3-byte copy.
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33;
    kick(8'h10, 8'h40, 8'd3);
    chk("basic_busy_first", {31'd0, busy}, 32'd1);
    wait_done(k);
    chk("basic_latency", k, 32'd6);
    step();
    chk("basic_busy_cnt", busy_cnt, 32'd6);
    chk("basic_wr_cnt",   wr_cnt,   32'd3);
    chk("basic_done_cnt", done_cnt, 32'd1);
    chk("basic_m40", {24'd0, mem[8'h40]}, 32'h11);
    chk("basic_m41", {24'd0, mem[8'h41]}, 32'h22);
    chk("basic_m42", {24'd0, mem[8'h42]}, 32'h33);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("basic_csum", {24'd0, checksum}, 32'h66);
`endif

    // Zero length.
    kick(8'h10, 8'h50, 8'd0);
    chk("zero_done", {31'd0, done}, 32'd1);
    step(); step();
    chk("zero_busy_cnt", busy_cnt, 32'd0);
    chk("zero_wr_cnt",   wr_cnt,   32'd0);
    chk("zero_done_cnt", done_cnt, 32'd1);

    // Address wrap: dst 0x01 is written before src 0x01 is read.
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hA2; mem[8'h00] = 8'hA3; mem[8'h01] = 8'hA4;
    kick(8'hFE, 8'h01, 8'd4);
    wait_done(k);
    chk("wrap_latency", k, 32'd8);
    step();
    chk("wrap_nrd", rd_q.size(), 32'd4);
    chk("wrap_nwr", wr_q.size(), 32'd4);
    if (rd_q.size() == 4 && wr_q.size() == 4) begin
      chk("wrap_rd0", {24'd0, rd_q[0]}, 32'hFE);
      chk("wrap_rd1", {24'd0, rd_q[1]}, 32'hFF);
      chk("wrap_rd2", {24'd0, rd_q[2]}, 32'h00);
      chk("wrap_rd3", {24'd0, rd_q[3]}, 32'h01);
      chk("wrap_wr0", {24'd0, wr_q[0]}, 32'h01);
      chk("wrap_wr3", {24'd0, wr_q[3]}, 32'h04);
    end
    chk("wrap_m01", {24'd0, mem[8'h01]}, 32'hA1);
    chk("wrap_m02", {24'd0, mem[8'h02]}, 32'hA2);
    chk("wrap_m03", {24'd0, mem[8'h03]}, 32'hA3);
    chk("wrap_m04", {24'd0, mem[8'h04]}, 32'hA1);

    // Overlapping forward copy with a start pulse while busy.
    mem[8'h05] = 8'hA5; mem[8'h06] = 8'h16; mem[8'h07] = 8'h17; mem[8'h08] = 8'h18;
    kick(8'h05, 8'h06, 8'd3);
    step();
    src_addr = 8'h10; dst_addr = 8'h90; len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(k);
    for (int i = 0; i < 6; i++) step();
    chk("ovl_done_cnt", done_cnt, 32'd1);
    chk("ovl_busy_cnt", busy_cnt, 32'd6);
    chk("ovl_m06", {24'd0, mem[8'h06]}, 32'hA5);
    chk("ovl_m07", {24'd0, mem[8'h07]}, 32'hA5);
    chk("ovl_m08", {24'd0, mem[8'h08]}, 32'hA5);
    chk("ovl_m90", {24'd0, mem[8'h90]}, 32'h00);

    // src == dst leaves data unchanged.
    mem[8'h30] = 8'h5C;
    kick(8'h30, 8'h30, 8'd1);
    wait_done(k);
    step();
    chk("same_wr_cnt", wr_cnt, 32'd1);
    chk("same_m30", {24'd0, mem[8'h30]}, 32'h5C);

`ifdef MEM_COPY_CHECKSUM_EN
    mem[8'hA0] = 8'h80; mem[8'hA1] = 8'h90; mem[8'hA2] = 8'h10;
    kick(8'hA0, 8'hC0, 8'd3);
    wait_done(k);
    chk("csum_at_done", {24'd0, checksum}, 32'h20);
    for (int i = 0; i < 4; i++) step();
    chk("csum_held", {24'd0, checksum}, 32'h20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
